// File: rtl/pedometer_stepcore.sv
// Step detector: weighted two-axis score, hysteresis/refractory FSM, saturating counter; 3-edge sample-to-step latency.
// No backpressure: a sample is taken whenever countSteps && sample_valid, and in-flight samples always drain.
module pedometer_stepcore #(
   parameter int DW      = 8,
   parameter int CNT_W   = 16,
   parameter int ADDR_W  = 3,
   parameter int REFRACT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              countSteps,
   input  logic              sample_valid,
   input  logic [DW-1:0]     A,
   input  logic [DW-1:0]     B,
   input  logic              updateWeight,
   input  logic              dualUpdateWeights,
   input  logic [ADDR_W-1:0] Addr1,
   input  logic [ADDR_W-1:0] Addr2,
   input  logic [DW-1:0]     Data1,
   input  logic [DW-1:0]     Data2,
   input  logic              clearSteps,
   output logic              step,
   output logic [CNT_W-1:0]  totalSteps,
   output logic              saturated,
   output logic [1:0]        state
);
   localparam int SW = 2*DW+1;
   localparam int RW = (REFRACT < 2) ? 1 : $clog2(REFRACT+1);

   typedef enum logic [1:0] {
      ST_ARMED   = 2'd0,
      ST_HIGH    = 2'd1,
      ST_REFRACT = 2'd2
   } st_t;

   logic [DW-1:0]    w_q [0:5];
   logic [DW-1:0]    w_d [0:5];
   logic             s0_vld_q;
   logic [DW-1:0]    a_q;
   logic [DW-1:0]    b_q;
   logic             s1_vld_q;
   logic [SW-1:0]    score_q;
   logic [SW-1:0]    score_d;
   logic [2*DW-1:0]  prod_a;
   logic [2*DW-1:0]  prod_b;
   logic [SW-1:0]    hi_thr;
   logic [SW-1:0]    lo_thr;
   st_t              state_q;
   st_t              state_d;
   logic [RW-1:0]    rc_q;
   logic [RW-1:0]    rc_d;
   logic             step_q;
   logic             step_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Port 2 is applied after port 1 so it wins on a shared address.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         w_d[i] = w_q[i];
      end
      for (int i = 0; i < 6; i++) begin
         if (updateWeight && (32'(Addr1) == 32'(i))) w_d[i] = Data1;
      end
      for (int i = 0; i < 6; i++) begin
         if (dualUpdateWeights && (32'(Addr2) == 32'(i))) w_d[i] = Data2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_q[0] <= DW'(1);
         w_q[1] <= DW'(1);
         w_q[2] <= {1'b1, {(DW-1){1'b0}}};
         w_q[3] <= '0;
         w_q[4] <= '1;
         w_q[5] <= '0;
      end else begin
         w_q <= w_d;
      end
   end

   always_comb begin
      prod_a  = {{DW{1'b0}}, w_q[0]} * {{DW{1'b0}}, a_q};
      prod_b  = {{DW{1'b0}}, w_q[1]} * {{DW{1'b0}}, b_q};
      score_d = {1'b0, prod_a} + {1'b0, prod_b};
      hi_thr  = {1'b0, w_q[5], w_q[4]};
      lo_thr  = {1'b0, w_q[3], w_q[2]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_vld_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         s1_vld_q <= 1'b0;
         score_q  <= '0;
      end else begin
         s0_vld_q <= countSteps && sample_valid;
         a_q      <= A;
         b_q      <= B;
         s1_vld_q <= s0_vld_q;
         score_q  <= score_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_ARMED;
         rc_q    <= '0;
         step_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (s1_vld_q) begin
         case (state_q)
            ST_ARMED:   if (score_q >= hi_thr) state_d = ST_HIGH;
            ST_HIGH:    if (score_q < lo_thr) state_d = (REFRACT == 0) ? ST_ARMED : ST_REFRACT;
            ST_REFRACT: if (rc_q == RW'(1)) state_d = ST_ARMED;
            default:    state_d = ST_ARMED;
         endcase
      end
   end

   always_comb begin
      step_d = 1'b0;
      rc_d   = rc_q;
      if (s1_vld_q) begin
         case (state_q)
            ST_ARMED:   step_d = (score_q >= hi_thr);
            ST_HIGH:    if (score_q < lo_thr) rc_d = RW'(REFRACT);
            ST_REFRACT: rc_d = rc_q - RW'(1);
            default:    rc_d = '0;
         endcase
      end
   end

   // Clear overrides a coincident increment; the step pulse itself still fires.
   always_comb begin
      cnt_d = cnt_q;
      if (step_d && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
      if (clearSteps) cnt_d = '0;
   end

   assign step       = step_q;
   assign totalSteps = cnt_q;
   assign saturated  = &cnt_q;
   assign state      = state_q;
endmodule
